// File: rtl/layer_address_engine_pkg.sv
// gpu_layer_pkg: layer register block layout shared by the GPU units,
// the unpacked field struct, an unpack helper and the address engine
// state encoding.
package gpu_layer_pkg;

    localparam int LAYER_BLOCK_W       = 128;
    localparam int LAYER_POPULATED_BIT = 0;
    localparam int LAYER_SPRITE_BIT    = 1;
    localparam int LAYER_WIDTH_LSB     = 16;
    localparam int LAYER_HEIGHT_LSB    = 32;
    localparam int LAYER_XPOS_LSB      = 48;
    localparam int LAYER_YPOS_LSB      = 64;
    localparam int LAYER_NCHARS_LSB    = 96;
    localparam int LAYER_FIELD_W       = 16;
    localparam int LAYER_NCHARS_W      = 4;

    typedef struct packed {
        logic                      populated;
        logic                      is_sprite;
        logic [LAYER_FIELD_W-1:0]  width;
        logic [LAYER_FIELD_W-1:0]  height;
        logic [LAYER_FIELD_W-1:0]  xpos;
        logic [LAYER_FIELD_W-1:0]  ypos;
        logic [LAYER_NCHARS_W-1:0] nchars;
    } layer_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_CALC   = 3'd3,
        ST_EMIT   = 3'd4
    } state_e;

    function automatic layer_fields_t unpack_layer(input logic [LAYER_BLOCK_W-1:0] blk);
        layer_fields_t f;
        f.populated = blk[LAYER_POPULATED_BIT];
        f.is_sprite = blk[LAYER_SPRITE_BIT];
        f.width     = blk[LAYER_WIDTH_LSB  +: LAYER_FIELD_W];
        f.height    = blk[LAYER_HEIGHT_LSB +: LAYER_FIELD_W];
        f.xpos      = blk[LAYER_XPOS_LSB   +: LAYER_FIELD_W];
        f.ypos      = blk[LAYER_YPOS_LSB   +: LAYER_FIELD_W];
        f.nchars    = blk[LAYER_NCHARS_LSB +: LAYER_NCHARS_W];
        return f;
    endfunction

endpackage

// File: rtl/layer_address_engine_if.sv
// Request and result handshake bundle of the layer address engine.
//   master : pixel sequencer / fetch stage side (drives req_*, out_ready)
//   slave  : engine side (drives req_ready, out_*)
interface layer_address_engine_if #(
    parameter int COORD_W      = 16,
    parameter int IDX_W        = 2,
    parameter int RAM_ADDR_W   = 27,
    parameter int FLASH_ADDR_W = 30
);
    logic                    req_valid;
    logic                    req_ready;
    logic [COORD_W-1:0]      req_x;
    logic [COORD_W-1:0]      req_y;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_hit;
    logic                    out_last;
    logic [IDX_W-1:0]        out_layer;
    logic                    out_is_sprite;
    logic [COORD_W-1:0]      out_layer_x;
    logic [COORD_W-1:0]      out_layer_y;
    logic [RAM_ADDR_W-1:0]   out_ram_offset_bytes;
    logic [FLASH_ADDR_W-1:0] out_flash_offset_bits;

    modport master (
        output req_valid, req_x, req_y, out_ready,
        input  req_ready, out_valid, out_hit, out_last, out_layer, out_is_sprite,
               out_layer_x, out_layer_y, out_ram_offset_bytes, out_flash_offset_bits
    );

    modport slave (
        input  req_valid, req_x, req_y, out_ready,
        output req_ready, out_valid, out_hit, out_last, out_layer, out_is_sprite,
               out_layer_x, out_layer_y, out_ram_offset_bytes, out_flash_offset_bits
    );
endinterface

// File: rtl/layer_address_engine_hit_check.sv
// layer_hit_check: combinational test of whether pixel (x,y) lies inside
// a layer. Font layers span width*nchars horizontally. All bounds are
// computed one bit wider than needed so a layer near the top of the
// coordinate range never wraps back to small coordinates.
//   inputs : layer fields, pixel x/y      output : hit
module layer_hit_check #(
    parameter int COORD_W = 16,
    parameter int CHAR_W  = 4
) (
    input  logic               populated,
    input  logic               is_sprite,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic [CHAR_W-1:0]  nchars,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               hit
);
    localparam int EXT_W = COORD_W + CHAR_W + 1;
    localparam int SUM_W = EXT_W + 1;

    logic [EXT_W-1:0] extent_w_s;
    logic [SUM_W-1:0] x_end_s;
    logic [SUM_W-1:0] y_end_s;

    // Extent, widened end coordinates and the hit decision
    always_comb begin
        extent_w_s = is_sprite ? EXT_W'(width) : EXT_W'(width) * EXT_W'(nchars);
        x_end_s    = SUM_W'(xpos) + SUM_W'(extent_w_s);
        y_end_s    = SUM_W'(ypos) + SUM_W'(height);
        hit        = populated
                  && (width  != {COORD_W{1'b0}})
                  && (height != {COORD_W{1'b0}})
                  && (is_sprite || (nchars != {CHAR_W{1'b0}}))
                  && (x >= xpos) && (SUM_W'(x) < x_end_s)
                  && (y >= ypos) && (SUM_W'(y) < y_end_s);
    end
endmodule

// File: rtl/layer_address_engine.sv
// layer_address_engine: scans all layer blocks for one screen pixel and
// emits one result per covering layer (local coords + RAM byte offset for
// sprites or flash bit offset for fonts), or a single no-hit terminator.
//   clk, reset  : clock, synchronous active-high reset
//   layer_regs  : NUM_LAYERS flat 128-bit layer blocks (stable while busy)
//   bus         : request / result handshakes (slave side)
//   busy        : engine not idle
module layer_address_engine
    import gpu_layer_pkg::*;
#(
    parameter int NUM_LAYERS      = 4,
    parameter int COORD_W         = 16,
    parameter int CHAR_W          = 4,
    parameter int RAM_ADDR_W      = 27,
    parameter int FLASH_ADDR_W    = 30,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FIRST_HIT_ONLY  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LAYERS*128-1:0]     layer_regs,
    layer_address_engine_if.slave         bus,
    output logic                          busy
);
    localparam int IDX_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int PROD_W = CHAR_W + 2 * COORD_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [COORD_W-1:0]      x_q, x_d, y_q, y_d, lx_q, lx_d, ly_q, ly_d;
    logic [CHAR_W-1:0]       char_q, char_d;
    logic                    hit_seen_q, hit_seen_d;
    logic                    req_ready_q, req_ready_d, busy_q, busy_d;
    logic                    out_valid_q, out_valid_d, out_hit_q, out_hit_d;
    logic                    out_last_q, out_last_d, out_spr_q, out_spr_d;
    logic [IDX_W-1:0]        out_layer_q, out_layer_d;
    logic [COORD_W-1:0]      out_lx_q, out_lx_d, out_ly_q, out_ly_d;
    logic [RAM_ADDR_W-1:0]   out_ram_q, out_ram_d;
    logic [FLASH_ADDR_W-1:0] out_flash_q, out_flash_d;

    layer_fields_t           cur_s;
    logic [COORD_W-1:0]      cur_w_s, cur_h_s, cur_x_s, cur_y_s, lx_hit_s, lx_sub_s;
    logic                    cur_hit_s, remaining_s;
    logic [NUM_LAYERS-1:0]   la_hit_s;
    logic [PROD_W-1:0]       sprite_prod_s, font_prod_s;

    assign cur_s   = unpack_layer(layer_regs[LAYER_BLOCK_W*idx_q +: LAYER_BLOCK_W]);
    assign cur_w_s = COORD_W'(cur_s.width);
    assign cur_h_s = COORD_W'(cur_s.height);
    assign cur_x_s = COORD_W'(cur_s.xpos);
    assign cur_y_s = COORD_W'(cur_s.ypos);

    layer_hit_check #(.COORD_W(COORD_W), .CHAR_W(CHAR_W)) u_check (
        .populated(cur_s.populated), .is_sprite(cur_s.is_sprite),
        .width(cur_w_s), .height(cur_h_s), .xpos(cur_x_s), .ypos(cur_y_s),
        .nchars(CHAR_W'(cur_s.nchars)), .x(x_q), .y(y_q), .hit(cur_hit_s)
    );

    // Lookahead checkers: one per layer, used to decide out_last on a hit
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_la
        layer_fields_t la_f;
        assign la_f = unpack_layer(layer_regs[LAYER_BLOCK_W*gi +: LAYER_BLOCK_W]);
        layer_hit_check #(.COORD_W(COORD_W), .CHAR_W(CHAR_W)) u_la (
            .populated(la_f.populated), .is_sprite(la_f.is_sprite),
            .width(COORD_W'(la_f.width)), .height(COORD_W'(la_f.height)),
            .xpos(COORD_W'(la_f.xpos)), .ypos(COORD_W'(la_f.ypos)),
            .nchars(CHAR_W'(la_f.nchars)), .x(x_q), .y(y_q), .hit(la_hit_s[gi])
        );
    end

    // Datapath helpers: remaining-hit lookahead, divide step, offset products
    always_comb begin
        remaining_s = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (la_hit_s[i] && (i > int'(idx_q))) begin
                remaining_s = 1'b1;
            end else begin
                remaining_s = remaining_s;
            end
        end
        lx_hit_s      = x_q - cur_x_s;
        lx_sub_s      = lx_q - cur_w_s;
        sprite_prod_s = (PROD_W'(ly_q) * PROD_W'(cur_w_s) + PROD_W'(lx_q))
                      * PROD_W'(BYTES_PER_PIXEL);
        font_prod_s   = PROD_W'(char_q) * PROD_W'(cur_w_s) * PROD_W'(cur_h_s)
                      + PROD_W'(ly_q) * PROD_W'(cur_w_s) + PROD_W'(lx_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;   idx_d = idx_q;     x_d = x_q;       y_d = y_q;
        lx_d = lx_q;         ly_d = ly_q;       char_d = char_q; hit_seen_d = hit_seen_q;
        out_valid_d = out_valid_q; out_hit_d = out_hit_q; out_last_d = out_last_q;
        out_layer_d = out_layer_q; out_spr_d = out_spr_q;  out_lx_d = out_lx_q;
        out_ly_d = out_ly_q;       out_ram_d = out_ram_q;  out_flash_d = out_flash_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    x_d = bus.req_x;  y_d = bus.req_y;
                    idx_d = {IDX_W{1'b0}};  hit_seen_d = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cur_hit_s) begin
                    lx_d = lx_hit_s;  ly_d = y_q - cur_y_s;  char_d = {CHAR_W{1'b0}};
                    // A font pixel already inside glyph 0 needs no divide step
                    if (cur_s.is_sprite || (lx_hit_s < cur_w_s)) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_DIVIDE;
                    end
                end else if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IDX_W'(1);
                end else if (hit_seen_q) begin
                    state_d = ST_IDLE;
                end else begin
                    // No layer covered the pixel: emit the terminator
                    out_valid_d = 1'b1;  out_hit_d = 1'b0;  out_last_d = 1'b1;
                    out_layer_d = {IDX_W{1'b0}};  out_spr_d = 1'b0;
                    out_lx_d = {COORD_W{1'b0}};   out_ly_d = {COORD_W{1'b0}};
                    out_ram_d = {RAM_ADDR_W{1'b0}};  out_flash_d = {FLASH_ADDR_W{1'b0}};
                    state_d = ST_EMIT;
                end
            end
            ST_DIVIDE: begin
                lx_d = lx_sub_s;  char_d = char_q + CHAR_W'(1);
                if (lx_sub_s < cur_w_s) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_CALC: begin
                out_valid_d = 1'b1;  out_hit_d = 1'b1;
                out_last_d  = (FIRST_HIT_ONLY != 0) || !remaining_s;
                out_layer_d = idx_q;  out_spr_d = cur_s.is_sprite;
                out_lx_d    = lx_q;   out_ly_d  = ly_q;
                out_ram_d   = cur_s.is_sprite ? RAM_ADDR_W'(sprite_prod_s) : {RAM_ADDR_W{1'b0}};
                out_flash_d = cur_s.is_sprite ? {FLASH_ADDR_W{1'b0}} : FLASH_ADDR_W'(font_prod_s);
                state_d     = ST_EMIT;
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    hit_seen_d = 1'b1;
                    out_valid_d = 1'b0;  out_hit_d = 1'b0;  out_last_d = 1'b0;
                    out_layer_d = {IDX_W{1'b0}};  out_spr_d = 1'b0;
                    out_lx_d = {COORD_W{1'b0}};   out_ly_d = {COORD_W{1'b0}};
                    out_ram_d = {RAM_ADDR_W{1'b0}};  out_flash_d = {FLASH_ADDR_W{1'b0}};
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        state_d = ST_CHECK;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;  idx_q <= '0;  x_q <= '0;  y_q <= '0;
            lx_q <= '0;  ly_q <= '0;  char_q <= '0;  hit_seen_q <= 1'b0;
            req_ready_q <= 1'b1;  busy_q <= 1'b0;
            out_valid_q <= 1'b0;  out_hit_q <= 1'b0;  out_last_q <= 1'b0;
            out_layer_q <= '0;  out_spr_q <= 1'b0;  out_lx_q <= '0;  out_ly_q <= '0;
            out_ram_q <= '0;  out_flash_q <= '0;
        end else begin
            state_q <= state_d;  idx_q <= idx_d;  x_q <= x_d;  y_q <= y_d;
            lx_q <= lx_d;  ly_q <= ly_d;  char_q <= char_d;  hit_seen_q <= hit_seen_d;
            req_ready_q <= req_ready_d;  busy_q <= busy_d;
            out_valid_q <= out_valid_d;  out_hit_q <= out_hit_d;  out_last_q <= out_last_d;
            out_layer_q <= out_layer_d;  out_spr_q <= out_spr_d;
            out_lx_q <= out_lx_d;  out_ly_q <= out_ly_d;
            out_ram_q <= out_ram_d;  out_flash_q <= out_flash_d;
        end
    end

    assign bus.req_ready             = req_ready_q;
    assign bus.out_valid             = out_valid_q;
    assign bus.out_hit               = out_hit_q;
    assign bus.out_last              = out_last_q;
    assign bus.out_layer             = out_layer_q;
    assign bus.out_is_sprite         = out_spr_q;
    assign bus.out_layer_x           = out_lx_q;
    assign bus.out_layer_y           = out_ly_q;
    assign bus.out_ram_offset_bytes  = out_ram_q;
    assign bus.out_flash_offset_bits = out_flash_q;
    assign busy                      = busy_q;
endmodule

// File: tb/tb_layer_address_engine.sv
// Directed testbench for layer_address_engine. A second instance built
// with FIRST_HIT_ONLY=1 shares the layer registers for the early-stop case.
module tb_layer_address_engine;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] regs = '0;
    logic         busy, busy_f;
    int           n_vec = 0;
    int           n_miss = 0;

    layer_address_engine_if #(.COORD_W(16), .IDX_W(2), .RAM_ADDR_W(27), .FLASH_ADDR_W(30)) bus ();
    layer_address_engine_if #(.COORD_W(16), .IDX_W(2), .RAM_ADDR_W(27), .FLASH_ADDR_W(30)) bus_f ();

    layer_address_engine #(.FIRST_HIT_ONLY(0)) dut (
        .clk(clk), .reset(reset), .layer_regs(regs), .bus(bus.slave), .busy(busy));
    layer_address_engine #(.FIRST_HIT_ONLY(1)) dut_f (
        .clk(clk), .reset(reset), .layer_regs(regs), .bus(bus_f.slave), .busy(busy_f));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic pop, input logic spr,
                                        input logic [15:0] w, input logic [15:0] h,
                                        input logic [15:0] xp, input logic [15:0] yp,
                                        input logic [3:0] n);
        logic [127:0] b;
        b = '0;
        b[0] = pop;  b[1] = spr;  b[16 +: 16] = w;  b[32 +: 16] = h;
        b[48 +: 16] = xp;  b[64 +: 16] = yp;  b[96 +: 4] = n;
        return b;
    endfunction

    // Waits for req_ready, then presents one request for a single cycle.
    task automatic do_request(input logic [15:0] x, input logic [15:0] y);
        int t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 200) begin @(negedge clk); t++; end
        if (!bus.req_ready) check_val("req_ready_timeout", 64'd0, 64'd1);
        bus.req_x = x;  bus.req_y = y;  bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Waits for out_valid (counting cycles since acceptance), checks every
    // field, then lets the handshake happen with out_ready high.
    task automatic expect_out(input string tag, input logic hit, input logic last,
                              input int layer, input logic spr, input int lx, input int ly,
                              input int ram, input int flash, input int lat);
        int n = 1;
        while (!bus.out_valid && n < 200) begin @(negedge clk); n++; end
        if (!bus.out_valid) begin
            check_val({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            if (lat > 0) check_val({tag, "_latency"}, 64'(n), 64'(lat));
            check_val({tag, "_hit"},   64'(bus.out_hit), 64'(hit));
            check_val({tag, "_last"},  64'(bus.out_last), 64'(last));
            check_val({tag, "_layer"}, 64'(bus.out_layer), 64'(layer));
            check_val({tag, "_spr"},   64'(bus.out_is_sprite), 64'(spr));
            check_val({tag, "_lx"},    64'(bus.out_layer_x), 64'(lx));
            check_val({tag, "_ly"},    64'(bus.out_layer_y), 64'(ly));
            check_val({tag, "_ram"},   64'(bus.out_ram_offset_bytes), 64'(ram));
            check_val({tag, "_flash"}, 64'(bus.out_flash_offset_bits), 64'(flash));
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;  bus.req_x = '0;  bus.req_y = '0;  bus.out_ready = 1'b1;
        bus_f.req_valid = 1'b0;  bus_f.req_x = '0;  bus_f.req_y = '0;  bus_f.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_busy",      64'(busy), 64'd0);
        check_val("rst_out_last",  64'(bus.out_last), 64'd0);

        // Sprite only, plus right-edge boundary
        regs = '0;
        regs[0 +: 128] = mk(1'b1, 1'b1, 16'd8, 16'd4, 16'd10, 16'd20, 4'd0);
        do_request(16'd13, 16'd22);
        expect_out("spr", 1'b1, 1'b1, 0, 1'b1, 3, 2, 38, 0, 3);
        do_request(16'd17, 16'd22);
        expect_out("spr_edge_in", 1'b1, 1'b1, 0, 1'b1, 7, 2, 46, 0, 3);
        do_request(16'd18, 16'd22);
        expect_out("spr_edge_out", 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0, 0);

        // Backpressure: ten stalled cycles with stable outputs
        bus.out_ready = 1'b0;
        do_request(16'd13, 16'd22);
        for (int i = 0; i < 3; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_val("bp_valid", 64'(bus.out_valid), 64'd1);
            check_val("bp_ram", 64'(bus.out_ram_offset_bytes), 64'd38);
            check_val("bp_req_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        expect_out("bp_release", 1'b1, 1'b1, 0, 1'b1, 3, 2, 38, 0, 0);

        // Font divide and the end-of-string boundary
        regs = '0;
        regs[128 +: 128] = mk(1'b1, 1'b0, 16'd6, 16'd8, 16'd0, 16'd0, 4'd5);
        do_request(16'd27, 16'd3);
        expect_out("font", 1'b1, 1'b1, 1, 1'b0, 3, 3, 0, 213, 0);
        do_request(16'd30, 16'd3);
        expect_out("font_end", 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0, 0);

        // Reset during DIVIDE, then a fresh request
        do_request(16'd27, 16'd3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        check_val("midrst_busy",      64'(busy), 64'd0);
        do_request(16'd27, 16'd3);
        expect_out("font_after_rst", 1'b1, 1'b1, 1, 1'b0, 3, 3, 0, 213, 0);

        // No wrap-around near the top of the coordinate range
        regs = '0;
        regs[0 +: 128] = mk(1'b1, 1'b1, 16'd4, 16'd4, 16'hFFFF, 16'd0, 4'd0);
        do_request(16'd1, 16'd1);
        expect_out("nowrap", 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0, 0);
        do_request(16'hFFFF, 16'd1);
        expect_out("top_hit", 1'b1, 1'b1, 0, 1'b1, 0, 1, 8, 0, 0);

        // Degenerate layers
        regs = '0;
        do_request(16'd5, 16'd5);
        expect_out("empty", 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0, 0);
        regs[0 +: 128] = mk(1'b1, 1'b1, 16'd0, 16'd4, 16'd0, 16'd0, 4'd0);
        do_request(16'd0, 16'd0);
        expect_out("width0", 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0, 0);
        regs[0 +: 128] = mk(1'b1, 1'b0, 16'd6, 16'd8, 16'd0, 16'd0, 4'd0);
        do_request(16'd1, 16'd1);
        expect_out("font0chars", 1'b0, 1'b1, 0, 1'b0, 0, 0, 0, 0, 0);

        // Multi-hit: layers 0, 2, 3 cover (5,5)
        regs = '0;
        regs[0   +: 128] = mk(1'b1, 1'b1, 16'd8, 16'd8, 16'd0, 16'd0, 4'd0);
        regs[256 +: 128] = mk(1'b1, 1'b1, 16'd4, 16'd4, 16'd4, 16'd4, 4'd0);
        regs[384 +: 128] = mk(1'b1, 1'b0, 16'd3, 16'd2, 16'd2, 16'd5, 4'd2);
        do_request(16'd5, 16'd5);
        expect_out("multi0", 1'b1, 1'b0, 0, 1'b1, 5, 5, 90, 0, 3);
        expect_out("multi2", 1'b1, 1'b0, 2, 1'b1, 1, 1, 10, 0, 0);
        expect_out("multi3", 1'b1, 1'b1, 3, 1'b0, 0, 0, 0, 6, 0);
        @(negedge clk);
        check_val("multi_done_ready", 64'(bus.req_ready), 64'd1);

        // First-hit-only instance on the same registers
        begin
            int t = 0;
            bus_f.req_x = 16'd5;  bus_f.req_y = 16'd5;  bus_f.req_valid = 1'b1;
            @(negedge clk);
            bus_f.req_valid = 1'b0;
            while (!bus_f.out_valid && t < 200) begin @(negedge clk); t++; end
            check_val("fho_valid", 64'(bus_f.out_valid), 64'd1);
            check_val("fho_layer", 64'(bus_f.out_layer), 64'd0);
            check_val("fho_last",  64'(bus_f.out_last), 64'd1);
            check_val("fho_ram",   64'(bus_f.out_ram_offset_bytes), 64'd90);
            @(negedge clk);
            check_val("fho_idle_ready", 64'(bus_f.req_ready), 64'd1);
            check_val("fho_idle_valid", 64'(bus_f.out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
